mfp_irq_ctrl: RTL

Parametrised interrupt priority controller, the next generation of the MFP interrupt logic. It generalises the fixed 16-source IER/IPR/IMR/ISR/VR structure to NUM_IRQ sources. It adds per-source edge polarity, per-source edge/level mode and a spurious-acknowledge path. It sits between interrupt sources (GPIO, timers, UARTs) and the 68000 IPL/IACK logic, and is register-mapped on the same byte-wide CPU bus as the rest of the peripheral.

---
 rtl/mfp_irq_ctrl_if.sv | 33 +++
 rtl/mfp_irq_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mfp_irq_ctrl_if.sv
// Bus and interrupt-line bundle for mfp_irq_ctrl.
// Roles:
//   master - the CPU bus and the interrupt sources.
//   slave  - the controller.
// vec_valid and spurious are one-cycle pulses with no ready/back-pressure:
// each asserts for exactly one clk after the iack rising edge it reports, and
// the consumer must sample it in that cycle.
interface mfp_irq_ctrl_if #(
  parameter int NUM_IRQ = 16
) ();
  logic               clk_en;
  logic               sel;
  logic               ds;
  logic               rw;
  logic [4:0]         addr;
  logic [7:0]         din;
  logic [7:0]         dout;
  logic [NUM_IRQ-1:0] src;
  logic               iack;
  logic               irq;
  logic               vec_valid;
  logic               spurious;

  modport master (
    output clk_en, sel, ds, rw, addr, din, src, iack,
    input  dout, irq, vec_valid, spurious
  );

  modport slave (
    input  clk_en, sel, ds, rw, addr, din, src, iack,
    output dout, irq, vec_valid, spurious
  );
endinterface

// File: rtl/mfp_irq_ctrl.sv
// Parametrised MFP-style interrupt priority controller.
// Register map (addr[4:2]): IER, IPR, ISR, IMR, AER, LVL, VR.
// Each register is split into byte lanes selected by addr[1:0].
// The highest-index pending, unmasked source wins.
// Acknowledge is taken on the rising edge of iack.
module mfp_irq_ctrl #(
  parameter  int NUM_IRQ = 16,
  localparam int IDXW    = $clog2(NUM_IRQ),
  localparam int NBYTES  = NUM_IRQ / 8
) (
  input  logic           clk,
  input  logic           reset_n,
  mfp_irq_ctrl_if.slave  bus
);

  logic [NUM_IRQ-1:0] ier_q, ier_d, ipr_q, ipr_d, isr_q, isr_d;
  logic [NUM_IRQ-1:0] imr_q, imr_d, aer_q, aer_d, lvl_q, lvl_d;
  logic [NUM_IRQ-1:0] p_q;
  logic [7:0]         vr_q, vr_d, vec_q, vec_d;
  logic               iack_q;
  logic               vec_valid_q, vec_valid_d, spurious_q, spurious_d;

  logic [2:0]         reg_idx;
  logic [1:0]         lane;
  logic               we, rd_en;
  logic               wr_ier, wr_ipr, wr_isr, wr_imr, wr_aer, wr_lvl, wr_vr;
  logic [NUM_IRQ-1:0] wmask, wdata, clr_bits;
  logic [NUM_IRQ-1:0] p, ev, pend, hp_oh, ipr_clr;
  logic [IDXW-1:0]    hp, hs;
  logic               pend_any, hs_valid, iack_rise, ack, spur;
  logic [NUM_IRQ-1:0] reg_val;
  logic [31:0]        reg_pad;
  logic [7:0]         rd_byte, dout_d;

  assign reg_idx  = bus.addr[4:2];
  assign lane     = bus.addr[1:0];
  assign we       = bus.clk_en & bus.sel & ~bus.ds & ~bus.rw;
  assign rd_en    = bus.sel & ~bus.ds & bus.rw;
  assign wr_ier   = we & (reg_idx == 3'd0);
  assign wr_ipr   = we & (reg_idx == 3'd1);
  assign wr_isr   = we & (reg_idx == 3'd2);
  assign wr_imr   = we & (reg_idx == 3'd3);
  assign wr_aer   = we & (reg_idx == 3'd4);
  assign wr_lvl   = we & (reg_idx == 3'd5);
  assign wr_vr    = we & (reg_idx == 3'd6) & (lane == 2'd0);
  assign wdata    = {NBYTES{bus.din}};
  assign clr_bits = wmask & ~wdata;

  // Active-high qualified sources; an AER flip can itself create an edge.
  assign p    = bus.src ~^ aer_q;
  assign ev   = p & ~p_q;
  assign pend = ipr_q & imr_q;

  // Byte-lane write mask; lanes beyond NBYTES select nothing.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (lane == b[1:0]) wmask[8*b +: 8] = 8'hFF;
    end
  end

  // Highest pending-unmasked index and highest in-service index.
  always_comb begin
    hp = '0;
    hs = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (pend[i])  hp = IDXW'(i);
      if (isr_q[i]) hs = IDXW'(i);
    end
  end

  assign pend_any  = |pend;
  assign hs_valid  = |isr_q;
  assign iack_rise = bus.iack & ~iack_q;
  assign ack       = iack_rise & pend_any;
  assign spur      = iack_rise & ~pend_any;
  assign hp_oh     = ack ? ({{(NUM_IRQ-1){1'b0}}, 1'b1} << hp) : '0;
  assign bus.irq   = pend_any & (~hs_valid | (hp > hs));

  // Next-state for all registers; acknowledge effects are applied last.
  always_comb begin
    ier_d = wr_ier ? ((ier_q & ~wmask) | (wdata & wmask)) : ier_q;
    imr_d = wr_imr ? ((imr_q & ~wmask) | (wdata & wmask)) : imr_q;
    aer_d = wr_aer ? ((aer_q & ~wmask) | (wdata & wmask)) : aer_q;
    lvl_d = wr_lvl ? ((lvl_q & ~wmask) | (wdata & wmask)) : lvl_q;
    vr_d  = wr_vr ? bus.din : vr_q;

    // Edge-mode clear sources; a same-cycle set overrides any clear.
    ipr_clr = (wr_ipr ? clr_bits : '0) | (wr_ier ? clr_bits : '0) | hp_oh;
    ipr_d   = (lvl_q & p & ier_q) | (~lvl_q & ((ipr_q & ~ipr_clr) | (ev & ier_q)));

    isr_d = isr_q;
    if (wr_isr) isr_d = isr_d & ~clr_bits;
    if (wr_vr && !bus.din[3]) isr_d = '0;
    if (vr_q[3]) isr_d = isr_d | hp_oh;

    vec_d = vec_q;
    if (ack)       vec_d = {vr_q[7:IDXW], hp};
    else if (spur) vec_d = {vr_q[7:IDXW], {IDXW{1'b0}}};
    vec_valid_d = ack;
    spurious_d  = spur;
  end

  // Read mux: register readback has priority over the acknowledge vector.
  always_comb begin
    case (reg_idx)
      3'd0:    reg_val = ier_q;
      3'd1:    reg_val = ipr_q;
      3'd2:    reg_val = isr_q;
      3'd3:    reg_val = imr_q;
      3'd4:    reg_val = aer_q;
      3'd5:    reg_val = lvl_q;
      default: reg_val = '0;
    endcase
    reg_pad = '0;
    reg_pad[NUM_IRQ-1:0] = reg_val;
    rd_byte = reg_pad[{lane, 3'b000} +: 8];
    if (reg_idx == 3'd6)      rd_byte = (lane == 2'd0) ? vr_q : 8'h00;
    else if (reg_idx == 3'd7) rd_byte = 8'h00;
    if (rd_en)         dout_d = rd_byte;
    else if (bus.iack) dout_d = vec_q;
    else               dout_d = 8'h00;
  end

  assign bus.dout      = dout_d;
  assign bus.vec_valid = vec_valid_q;
  assign bus.spurious  = spurious_q;

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ier_q       <= '0;
      ipr_q       <= '0;
      isr_q       <= '0;
      imr_q       <= '0;
      aer_q       <= '0;
      lvl_q       <= '0;
      p_q         <= '0;
      vr_q        <= '0;
      vec_q       <= '0;
      iack_q      <= 1'b0;
      vec_valid_q <= 1'b0;
      spurious_q  <= 1'b0;
    end else begin
      ier_q       <= ier_d;
      ipr_q       <= ipr_d;
      isr_q       <= isr_d;
      imr_q       <= imr_d;
      aer_q       <= aer_d;
      lvl_q       <= lvl_d;
      p_q         <= p;
      vr_q        <= vr_d;
      vec_q       <= vec_d;
      iack_q      <= bus.iack;
      vec_valid_q <= vec_valid_d;
      spurious_q  <= spurious_d;
    end
  end

endmodule
